idct_tpose_pingpong: RTL



---
 rtl/idct_tpose_pingpong.sv | 125 ++++++++++++
 1 files changed

// File: rtl/idct_tpose_pingpong.sv
// Ping-pong N x N transpose buffer between the row and column 1-D IDCT passes.
// One bank fills in row-major order while the other drains column- or row-major.
module idct_tpose_pingpong #(
  parameter int WIDTH_X = 16,
  parameter int N       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic               w_valid,
  output logic               w_ready,
  input  logic [WIDTH_X-1:0] w_data,
  output logic               r_valid,
  input  logic               r_ready,
  output logic [WIDTH_X-1:0] r_data,
  output logic               r_last,
  output logic [1:0]         bank_full
);

  localparam int LOG_N  = $clog2(N);
  localparam int ADDR_W = 2 * LOG_N;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N * N - 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

  // Per-bank state is kept in plain arrays so checkers can bind to it directly.
  bank_state_e bank_state     [2];
  bank_state_e bank_state_nxt [2];

  logic                wb;
  logic                rb;
  logic [ADDR_W-1:0]   w_cnt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [1:0]          mode_q;
  logic                w_fire;
  logic                fetch;
  logic [ADDR_W-1:0]   rd_addr;
  logic [WIDTH_X-1:0]  mem [2*N*N];

  // Handshakes: a sample moves when valid && ready at a rising clk edge; a
  // source holding valid keeps its data stable until ready is seen.

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_state[0] <= EMPTY;
      bank_state[1] <= EMPTY;
    end else begin
      bank_state[0] <= bank_state_nxt[0];
      bank_state[1] <= bank_state_nxt[1];
    end
  end

  // A bank cannot be both written and freed in one cycle: writes need
  // !FULL, the final fetch needs FULL.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_state_nxt[b] = bank_state[b];
      if (w_fire && wb == 1'(b)) begin
        if (w_cnt == LAST_ADDR)
          bank_state_nxt[b] = FULL;
        else if (w_cnt == '0)
          bank_state_nxt[b] = FILLING;
      end
      if (fetch && rb == 1'(b) && r_cnt == LAST_ADDR)
        bank_state_nxt[b] = EMPTY;
    end
  end

  always_comb begin
    w_ready   = (bank_state[wb] != FULL);
    w_fire    = w_valid && w_ready;
    fetch     = (bank_state[rb] == FULL) && (!r_valid || r_ready);
    bank_full = {bank_state[1] == FULL, bank_state[0] == FULL};
    // Transposed read: row = r_cnt mod N, col = r_cnt div N, addr = row*N + col.
    rd_addr   = mode_q[rb] ? {r_cnt[LOG_N-1:0], r_cnt[ADDR_W-1:LOG_N]} : r_cnt;
  end

  always_ff @(posedge clk) begin
    if (w_fire)
      mem[{wb, w_cnt}] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb      <= 1'b0;
      rb      <= 1'b0;
      w_cnt   <= '0;
      r_cnt   <= '0;
      mode_q  <= 2'b00;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else begin
      if (w_fire) begin
        if (w_cnt == '0)
          mode_q[wb] <= mode;
        if (w_cnt == LAST_ADDR) begin
          w_cnt <= '0;
          wb    <= ~wb;
        end else begin
          w_cnt <= w_cnt + ADDR_W'(1);
        end
      end
      if (fetch) begin
        r_valid <= 1'b1;
        r_data  <= mem[{rb, rd_addr}];
        r_last  <= (r_cnt == LAST_ADDR);
        if (r_cnt == LAST_ADDR) begin
          r_cnt <= '0;
          rb    <= ~rb;
        end else begin
          r_cnt <= r_cnt + ADDR_W'(1);
        end
      end else if (r_ready) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

endmodule
